l2_train_sched: RTL and testbench

L2_TRAIN_SCHED -- requirements
Module: l2_train_sched

---
 rtl/l2_train_sched.sv | 248 ++++++++++++++++++++++++
 tb/tb_l2_train_sched.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_train_sched.sv
`default_nettype none
// ============================================================================
// Module   : l2_train_sched
// Purpose  : Run scheduler for an L2 trainer. Requests samples, emits a delayed
//            one-hot label pulse, waits for the trainer window and counts hits
//            per epoch. Define L2_SCHED_TIMEOUT_EN to bound the window wait.
// Revision : 1.0 - initial release
// ============================================================================
module l2_train_sched #(
    parameter int p_samples     = 16,
    parameter int p_epochs      = 8,
    parameter int p_label_delay = 4,
    parameter int p_timeout     = 63
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic       i_sample_valid,
    input  logic [2:0] i_sample_label,
    input  logic       i_gas,
    input  logic       i_las,
    output logic       o_sample_req,
    output logic [2:0] o_label,
    output logic       o_endof_epochs,
    output logic       o_busy,
    output logic [7:0] o_sample_cnt,
    output logic [7:0] o_epoch_cnt,
    output logic [7:0] o_epoch_hits,
    output logic [7:0] o_timeout_cnt
);

    localparam logic [3:0] c_S_IDLE       = 4'd0;
    localparam logic [3:0] c_S_REQ        = 4'd1;
    localparam logic [3:0] c_S_WAIT_S     = 4'd2;
    localparam logic [3:0] c_S_DELAY      = 4'd3;
    localparam logic [3:0] c_S_LABEL      = 4'd4;
    localparam logic [3:0] c_S_WAIT_OPEN  = 4'd5;
    localparam logic [3:0] c_S_WAIT_CLOSE = 4'd6;
    localparam logic [3:0] c_S_NEXT       = 4'd7;
    localparam logic [3:0] c_S_DONE       = 4'd8;

    localparam logic [7:0] c_LAST_SAMPLE = 8'(p_samples - 1);
    localparam logic [7:0] c_LAST_EPOCH  = 8'(p_epochs - 1);
    localparam logic [7:0] c_DLY_LAST    = 8'(p_label_delay - 1);

    logic [3:0] state_q, state_d;
    logic [7:0] sample_cnt_q, sample_cnt_d;
    logic [7:0] epoch_cnt_q, epoch_cnt_d;
    logic [7:0] epoch_hits_q, epoch_hits_d;
    logic [7:0] acc_q, acc_d;
    logic [7:0] dly_q, dly_d;
    logic [2:0] label_q, label_d;
    logic       hit_q, hit_d;

    logic       w_start_run;
    logic       w_label_ok;
    logic       w_last_sample;
    logic       w_last_epoch;
    logic       w_in_window;
    logic       w_waiting;
    logic       w_tmo_last;
    logic       w_timeout;
    logic [7:0] w_acc_sum;

    assign w_start_run   = i_start && (state_q == c_S_IDLE || state_q == c_S_DONE);
    assign w_label_ok    = (i_sample_label == 3'b001) || (i_sample_label == 3'b010) ||
                           (i_sample_label == 3'b100);
    assign w_last_sample = (sample_cnt_q == c_LAST_SAMPLE);
    assign w_last_epoch  = (epoch_cnt_q == c_LAST_EPOCH);
    assign w_waiting     = (state_q == c_S_WAIT_OPEN) || (state_q == c_S_WAIT_CLOSE);
    assign w_in_window   = (state_q == c_S_LABEL) || w_waiting;
    assign w_acc_sum     = acc_q + {7'd0, hit_q};

    // A timeout only fires when the normal window transition is not taken this cycle.
    assign w_timeout = w_tmo_last &&
                       (((state_q == c_S_WAIT_OPEN) && !i_gas) ||
                        ((state_q == c_S_WAIT_CLOSE) && i_gas));

`ifdef L2_SCHED_TIMEOUT_EN
    localparam logic [7:0] c_TMO_LAST = 8'(p_timeout - 1);

    logic [7:0] tmo_q, tmo_d;
    logic [7:0] timeout_cnt_q, timeout_cnt_d;

    assign w_tmo_last = (tmo_q == c_TMO_LAST);

    always_comb begin
        tmo_d         = tmo_q;
        timeout_cnt_d = timeout_cnt_q;
        if (state_q == c_S_LABEL) begin
            tmo_d = 8'd0;
        end else if (w_waiting) begin
            tmo_d = tmo_q + 8'd1;
        end
        if (w_start_run) begin
            timeout_cnt_d = 8'd0;
        end else if (w_timeout && timeout_cnt_q != 8'hFF) begin
            timeout_cnt_d = timeout_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tmo_q         <= 8'd0;
            timeout_cnt_q <= 8'd0;
        end else begin
            tmo_q         <= tmo_d;
            timeout_cnt_q <= timeout_cnt_d;
        end
    end

    assign o_timeout_cnt = timeout_cnt_q;
`else
    logic [7:0] w_unused_tmo;

    assign w_unused_tmo  = 8'(p_timeout);
    assign w_tmo_last    = 1'b0;
    assign o_timeout_cnt = 8'd0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= c_S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_S_IDLE: begin
                if (i_start) state_d = c_S_REQ;
            end
            c_S_REQ: begin
                state_d = c_S_WAIT_S;
            end
            c_S_WAIT_S: begin
                if (i_sample_valid) begin
                    if (!w_label_ok)             state_d = c_S_NEXT;
                    else if (p_label_delay == 0) state_d = c_S_LABEL;
                    else                         state_d = c_S_DELAY;
                end
            end
            c_S_DELAY: begin
                if (dly_q == c_DLY_LAST) state_d = c_S_LABEL;
            end
            c_S_LABEL: begin
                state_d = c_S_WAIT_OPEN;
            end
            c_S_WAIT_OPEN: begin
                if (i_gas)          state_d = c_S_WAIT_CLOSE;
                else if (w_timeout) state_d = c_S_NEXT;
            end
            c_S_WAIT_CLOSE: begin
                if (!i_gas || w_timeout) state_d = c_S_NEXT;
            end
            c_S_NEXT: begin
                if (w_last_sample && w_last_epoch) state_d = c_S_DONE;
                else                               state_d = c_S_REQ;
            end
            c_S_DONE: begin
                if (i_start) state_d = c_S_REQ;
            end
            default: begin
                state_d = c_S_IDLE;
            end
        endcase
    end

    always_comb begin
        sample_cnt_d = sample_cnt_q;
        epoch_cnt_d  = epoch_cnt_q;
        epoch_hits_d = epoch_hits_q;
        acc_d        = acc_q;
        dly_d        = dly_q;
        label_d      = label_q;
        hit_d        = hit_q;

        case (state_q)
            c_S_WAIT_S: begin
                dly_d = 8'd0;
                if (i_sample_valid) label_d = i_sample_label;
            end
            c_S_DELAY: begin
                dly_d = dly_q + 8'd1;
            end
            c_S_NEXT: begin
                if (w_last_sample) begin
                    sample_cnt_d = 8'd0;
                    epoch_hits_d = w_acc_sum;
                    acc_d        = 8'd0;
                    if (!w_last_epoch) epoch_cnt_d = epoch_cnt_q + 8'd1;
                end else begin
                    sample_cnt_d = sample_cnt_q + 8'd1;
                    acc_d        = w_acc_sum;
                end
            end
            default: begin
            end
        endcase

        // The hit flag lives from LABEL to NEXT; a timed-out window never scores.
        if (w_in_window && i_las) hit_d = 1'b1;
        if (w_timeout || state_q == c_S_NEXT) hit_d = 1'b0;

        if (w_start_run) begin
            sample_cnt_d = 8'd0;
            epoch_cnt_d  = 8'd0;
            epoch_hits_d = 8'd0;
            acc_d        = 8'd0;
            hit_d        = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sample_cnt_q <= 8'd0;
            epoch_cnt_q  <= 8'd0;
            epoch_hits_q <= 8'd0;
            acc_q        <= 8'd0;
            dly_q        <= 8'd0;
            label_q      <= 3'b000;
            hit_q        <= 1'b0;
        end else begin
            sample_cnt_q <= sample_cnt_d;
            epoch_cnt_q  <= epoch_cnt_d;
            epoch_hits_q <= epoch_hits_d;
            acc_q        <= acc_d;
            dly_q        <= dly_d;
            label_q      <= label_d;
            hit_q        <= hit_d;
        end
    end

    always_comb begin
        o_sample_req   = (state_q == c_S_REQ);
        o_label        = (state_q == c_S_LABEL) ? label_q : 3'b000;
        o_endof_epochs = (state_q == c_S_DONE);
        o_busy         = (state_q != c_S_IDLE) && (state_q != c_S_DONE);
    end

    assign o_sample_cnt = sample_cnt_q;
    assign o_epoch_cnt  = epoch_cnt_q;
    assign o_epoch_hits = epoch_hits_q;

endmodule
`default_nettype wire

// File: tb/tb_l2_train_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_l2_train_sched
// Purpose  : Directed self-checking bench for l2_train_sched with a label
//            scoreboard (expected label and arrival cycle queued at accept).
// Revision : 1.0 - initial release
// ============================================================================
module tb_l2_train_sched;

    localparam int NS = 3;
    localparam int NE = 2;
    localparam int LD = 4;
    localparam int TO = 10;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       valid = 1'b0;
    logic [2:0] slabel = 3'b000;
    logic       gas   = 1'b0;
    logic       las   = 1'b0;

    logic       o_sample_req;
    logic [2:0] o_label;
    logic       o_endof_epochs;
    logic       o_busy;
    logic [7:0] o_sample_cnt;
    logic [7:0] o_epoch_cnt;
    logic [7:0] o_epoch_hits;
    logic [7:0] o_timeout_cnt;

    l2_train_sched #(
        .p_samples     (NS),
        .p_epochs      (NE),
        .p_label_delay (LD),
        .p_timeout     (TO)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_start        (start),
        .i_sample_valid (valid),
        .i_sample_label (slabel),
        .i_gas          (gas),
        .i_las          (las),
        .o_sample_req   (o_sample_req),
        .o_label        (o_label),
        .o_endof_epochs (o_endof_epochs),
        .o_busy         (o_busy),
        .o_sample_cnt   (o_sample_cnt),
        .o_epoch_cnt    (o_epoch_cnt),
        .o_epoch_hits   (o_epoch_hits),
        .o_timeout_cnt  (o_timeout_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    logic [2:0] q_lab[$];
    int         q_cyc[$];

    int exp_s    = 0;
    int exp_e    = 0;
    int exp_hits = 0;
    int acc      = 0;

`ifdef L2_SCHED_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    task automatic chk(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    always @(negedge clk) begin
        if (o_label !== 3'b000) begin
            if (q_lab.size() == 0) begin
                chk("label_unexpected", int'(o_label), 0);
            end else begin
                logic [2:0] el;
                int         ec;
                el = q_lab.pop_front();
                ec = q_cyc.pop_front();
                chk("label_value", int'(o_label), int'(el));
                chk("label_cycle", cyc, ec);
            end
        end
    end

    task automatic wait_req();
        int n = 0;
        while (o_sample_req !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (o_sample_req !== 1'b1) begin
            $display("FAIL wait_req observed=no_request expected=request (TB_RESULT checks=%0d failures=%0d)",
                     checks, failures + 1);
            $fatal(1, "sample request never arrived");
        end
    endtask

    task automatic wait_label();
        int n = 0;
        while (o_label === 3'b000 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (o_label === 3'b000) chk("label_missing", 0, 1);
    endtask

    task automatic model_done(input bit scored);
        if (scored) acc++;
        if (exp_s == NS - 1) begin
            exp_hits = acc;
            acc      = 0;
            exp_s    = 0;
            if (exp_e != NE - 1) exp_e++;
        end else begin
            exp_s++;
        end
    endtask

    // One full sample: request, accept, label, optional las, window (or timeout).
    task automatic do_sample(input logic [2:0] lab, input bit hit, input bit gas_on);
        bit onehot;
        int lc;
        wait_req();
        chk("sample_cnt", int'(o_sample_cnt), exp_s);
        chk("epoch_cnt", int'(o_epoch_cnt), exp_e);
        chk("epoch_hits", int'(o_epoch_hits), exp_hits);
        chk("busy_in_run", int'(o_busy), 1);
        @(negedge clk);
        chk("req_one_cycle", int'(o_sample_req), 0);
        valid  = 1'b1;
        slabel = lab;
        @(negedge clk);
        valid  = 1'b0;
        slabel = 3'b000;
        onehot = ($countones(lab) == 1);
        if (onehot) begin
            q_lab.push_back(lab);
            q_cyc.push_back(cyc + LD);
            wait_label();
            lc  = cyc;
            las = hit;
            @(negedge clk);
            las = 1'b0;
            if (gas_on) begin
                gas = 1'b1;
                repeat (3) @(negedge clk);
                gas = 1'b0;
            end else begin
                wait_req();
                chk("timeout_req_cycle", cyc, lc + TO + 2);
                chk("timeout_cnt", int'(o_timeout_cnt), 1);
            end
        end
        model_done(onehot && hit && gas_on);
    endtask

    initial begin
        #2;
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_req", int'(o_sample_req), 0);
        chk("rst_endof", int'(o_endof_epochs), 0);
        chk("rst_sample_cnt", int'(o_sample_cnt), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_no_req", int'(o_sample_req), 0);
        chk("idle_not_busy", int'(o_busy), 0);

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        // Epoch 0: hit, malformed label, hit -> 2 hits.
        do_sample(3'b010, 1'b1, 1'b1);
        do_sample(3'b011, 1'b1, 1'b1);
        do_sample(3'b100, 1'b1, 1'b1);
        // Epoch 1: miss, then a timeout (or plain hit), then hit.
        do_sample(3'b001, 1'b0, 1'b1);
        do_sample(3'b001, 1'b1, !TMO_EN);
        do_sample(3'b010, 1'b1, 1'b1);

        begin
            int n = 0;
            while (o_endof_epochs !== 1'b1 && n < 50) begin
                @(negedge clk);
                n++;
            end
        end
        repeat (2) @(negedge clk);
        chk("done_endof", int'(o_endof_epochs), 1);
        chk("done_busy", int'(o_busy), 0);
        chk("done_epoch_cnt", int'(o_epoch_cnt), NE - 1);
        chk("done_sample_cnt", int'(o_sample_cnt), 0);
        chk("done_epoch_hits", int'(o_epoch_hits), exp_hits);
        chk("done_timeout_cnt", int'(o_timeout_cnt), TMO_EN ? 1 : 0);

        // Restart from DONE clears everything on the same edge.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        exp_s = 0; exp_e = 0; exp_hits = 0; acc = 0;
        chk("restart_endof", int'(o_endof_epochs), 0);
        chk("restart_timeout_cnt", int'(o_timeout_cnt), 0);
        do_sample(3'b100, 1'b1, 1'b1);

        // Second sample: stop in WAIT_CLOSE, poke start, then reset asynchronously.
        wait_req();
        chk("pre_rst_sample_cnt", int'(o_sample_cnt), 1);
        @(negedge clk);
        valid  = 1'b1;
        slabel = 3'b001;
        @(negedge clk);
        valid  = 1'b0;
        slabel = 3'b000;
        q_lab.push_back(3'b001);
        q_cyc.push_back(cyc + LD);
        wait_label();
        @(negedge clk);
        gas = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_start_no_req", int'(o_sample_req), 0);
        chk("busy_start_busy", int'(o_busy), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_busy", int'(o_busy), 0);
        chk("async_rst_sample_cnt", int'(o_sample_cnt), 0);
        chk("async_rst_label", int'(o_label), 0);
        chk("async_rst_endof", int'(o_endof_epochs), 0);
        chk("async_rst_epoch_cnt", int'(o_epoch_cnt), 0);
        chk("async_rst_timeout_cnt", int'(o_timeout_cnt), 0);
        gas = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("post_rst_idle_req", int'(o_sample_req), 0);
        chk("post_rst_idle_busy", int'(o_busy), 0);

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        exp_s = 0; exp_e = 0; exp_hits = 0; acc = 0;
        wait_req();
        chk("resume_sample_cnt", int'(o_sample_cnt), 0);
        chk("queue_drained", q_lab.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
